// File: rtl/mips_controller_if.sv
// Control bus between the multicycle MIPS controller and its datapath:
// instruction fields and zero flag in, mux selects, enables and debug state out.
interface mips_controller_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic [1:0]  pcsource;
  logic        pcen;
  logic        iord;
  logic        irwrite;
  logic        regwrite;
  logic        regdst;
  logic        memtoreg;
  logic        memwrite;
  logic [2:0]  alucontrol;
  logic [31:0] instret;
  logic [3:0]  state;

  modport master (
    input  op, funct, zero,
    output alusrca, alusrcb, pcsource, pcen, iord, irwrite, regwrite,
           regdst, memtoreg, memwrite, alucontrol, instret, state
  );

  modport slave (
    output op, funct, zero,
    input  alusrca, alusrcb, pcsource, pcen, iord, irwrite, regwrite,
           regdst, memtoreg, memwrite, alucontrol, instret, state
  );
endinterface

// File: rtl/mips_controller.sv
// Multicycle MIPS control unit: Moore FSM driving datapath selects/enables,
// plus a retired-instruction counter.
//
//   state        | meaning
//   FETCH   (0)  | read instruction at PC, PC <= PC + 1
//   DECODE  (1)  | read registers, ALUOut <= branch target
//   MEMADR  (2)  | compute load/store address
//   MEMRD   (3)  | read data memory
//   MEMWB   (4)  | write loaded word to rt
//   MEMWR   (5)  | write B to data memory
//   RTYPEEX (6)  | ALU op selected by funct
//   RTYPEWB (7)  | write ALU result to rd
//   BEQEX   (8)  | compare, branch if zero
//   ADDIEX  (9)  | A + imm
//   ADDIWB  (10) | write ALU result to rt
//   JEX     (11) | PC <= jump target
module mips_controller (
  input  logic clk,
  input  logic reset,
  mips_controller_if.master bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JEX    = 4'd11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instret_q;
  logic        pcwrite, branch;
  logic [2:0]  funct_alu;
  logic        funct_ok;

  always_comb begin
    funct_ok = 1'b1;
    case (bus.funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      6'b000000: funct_alu = 3'b011;
      6'b000010: funct_alu = 3'b100;
      default: begin
        funct_alu = 3'b010;
        funct_ok  = 1'b0;
      end
    endcase
  end

  // Every return to FETCH retires one instruction, NOPs and illegal states included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_d == FETCH && state_q != FETCH) instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsource   = 2'b00;
    bus.iord       = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regwrite   = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.memwrite   = 1'b0;
    bus.alucontrol = 3'b010;
    pcwrite        = 1'b0;
    branch         = 1'b0;
    case (state_q)
      FETCH: begin
        bus.iord    = 1'b1;
        bus.irwrite = 1'b1;
        bus.alusrcb = 2'b01;
        pcwrite     = 1'b1;
      end
      DECODE:  bus.alusrcb = 2'b11;
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      MEMWR:   bus.memwrite = 1'b1;
      RTYPEEX: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = funct_alu;
      end
      RTYPEWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = funct_ok;
      end
      BEQEX: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = 3'b110;
        bus.pcsource   = 2'b01;
        branch         = 1'b1;
      end
      ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      ADDIWB:  bus.regwrite = 1'b1;
      JEX: begin
        bus.pcsource = 2'b10;
        pcwrite      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pcen    = pcwrite | (branch & bus.zero);
  assign bus.state   = state_q;
  assign bus.instret = instret_q;
endmodule
